// File: rtl/gpio_defaults_pkg.sv
// Shared types and constants for the GPIO power-on defaults serializer.
// Mode-word constants and a helper that assembles a DEFAULTS vector.
package gpio_defaults_pkg;

    localparam int unsigned DEF_WIDTH = 10;
    localparam int unsigned MAX_GPIO  = 64;

    localparam logic [DEF_WIDTH-1:0] MGMT_STD_ANALOG        = 10'h000;
    localparam logic [DEF_WIDTH-1:0] USER_STD_INPUT_NOPULL  = 10'h008;
    localparam logic [DEF_WIDTH-1:0] MGMT_STD_INPUT_NOPULL  = 10'h009;
    localparam logic [DEF_WIDTH-1:0] MGMT_STD_OUTPUT        = 10'h00b;
    localparam logic [DEF_WIDTH-1:0] MGMT_STD_INPUT_PULLDN  = 10'h049;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLoad
    } gpio_ser_state_e;

    // Channel k lands in bits [k*DEF_WIDTH +: DEF_WIDTH]; unused channels stay zero.
    function automatic logic [MAX_GPIO*DEF_WIDTH-1:0] pack_defaults(
        input logic [DEF_WIDTH-1:0] modes [MAX_GPIO],
        input int unsigned          num
    );
        logic [MAX_GPIO*DEF_WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < MAX_GPIO; k++) begin
            if (k < num) begin
                v[k*DEF_WIDTH +: DEF_WIDTH] = modes[k];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/gpio_serial_clkgen.sv
// Bit-slot phase counter for the defaults serializer: one slot is 2*CLK_DIV
// clk cycles, serial_clock low for the first half and high for the second.
module gpio_serial_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_run,
    input  logic i_clk_en,
    output logic o_slot_start,
    output logic o_rise_edge,
    output logic o_serial_clock
);

    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_RISE = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_phase;
    logic          r_sclk;

    // Pulses mark the cycle whose closing clk edge starts a slot / raises the clock.
    assign o_slot_start   = i_run && (r_phase == PHASE_LAST);
    assign o_rise_edge    = i_run && (r_phase == PHASE_RISE);
    assign o_serial_clock = r_sclk;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_phase <= '0;
        end else if (!i_run || o_slot_start) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sclk <= 1'b0;
        end else if (!i_clk_en) begin
            r_sclk <= 1'b0;
        end else if (o_rise_edge) begin
            r_sclk <= 1'b1;
        end else if (o_slot_start) begin
            r_sclk <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_defaults_serializer.sv
// Shadow array of GPIO power-on configuration words, shifted serially into the
// per-pad control chain after every reset and on request, then load-strobed.
module gpio_defaults_serializer
    import gpio_defaults_pkg::*;
#(
    parameter int unsigned NUM_GPIO = 19,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter logic [NUM_GPIO*WIDTH-1:0] DEFAULTS = {NUM_GPIO{WIDTH'(MGMT_STD_INPUT_NOPULL)}},
    parameter int unsigned CLK_DIV  = 2,
    localparam int unsigned IDX_W   = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_start,
    input  logic             i_cfg_we,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic [WIDTH-1:0] i_cfg_wdata,
    output logic [WIDTH-1:0] o_cfg_rdata,
    output logic             o_cfg_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_serial_clock,
    output logic             o_serial_load,
    output logic             o_serial_data
);

    localparam int unsigned TOTAL = NUM_GPIO * WIDTH;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);

    gpio_ser_state_e r_state;
    gpio_ser_state_e w_state_next;

    logic [WIDTH-1:0] r_shadow [NUM_GPIO];
    logic [TOTAL-1:0] r_shreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_auto_start;
    logic             r_done;
    logic             r_load;

    logic             w_idle;
    logic             w_go;
    logic             w_wr_ok;
    logic             w_slot_start;
    logic             w_rise_edge;
    logic             w_last_bit;
    logic [TOTAL-1:0] w_stream;

    assign w_idle     = (r_state == StIdle);
    assign w_go       = w_idle && (r_auto_start || i_start);
    assign w_wr_ok    = w_idle && i_cfg_we;
    assign w_last_bit = (r_bit_cnt == LAST_BIT);

    gpio_serial_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .i_clk          (i_clk),
        .i_resetn       (i_resetn),
        .i_run          (!w_idle),
        .i_clk_en       (r_state == StShift),
        .o_slot_start   (w_slot_start),
        .o_rise_edge    (w_rise_edge),
        .o_serial_clock (o_serial_clock)
    );

    // Out-of-range indices match no channel, so such writes drop and reads return 0.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int k = 0; k < NUM_GPIO; k++) begin
                r_shadow[k] <= DEFAULTS[k*WIDTH +: WIDTH];
            end
        end else if (w_wr_ok) begin
            for (int k = 0; k < NUM_GPIO; k++) begin
                if (i_cfg_idx == IDX_W'(k)) begin
                    r_shadow[k] <= i_cfg_wdata;
                end
            end
        end
    end

    always_comb begin
        o_cfg_rdata = '0;
        for (int k = 0; k < NUM_GPIO; k++) begin
            if (i_cfg_idx == IDX_W'(k)) begin
                o_cfg_rdata = r_shadow[k];
            end
        end
    end

    // Snapshot source: includes a write committing in the same cycle as start.
    always_comb begin
        w_stream = '0;
        for (int k = 0; k < NUM_GPIO; k++) begin
            if (w_wr_ok && (i_cfg_idx == IDX_W'(k))) begin
                w_stream[k*WIDTH +: WIDTH] = i_cfg_wdata;
            end else begin
                w_stream[k*WIDTH +: WIDTH] = r_shadow[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_go) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (w_slot_start && w_last_bit) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                if (w_slot_start) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // MSB of the shift register is the line; the final shift empties it, leaving data low.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_auto_start <= 1'b1;
            r_done       <= 1'b0;
            r_load       <= 1'b0;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
        end else begin
            r_load <= (w_state_next == StLoad);
            if (w_go) begin
                r_auto_start <= 1'b0;
                r_done       <= 1'b0;
                r_shreg      <= w_stream;
                r_bit_cnt    <= '0;
            end else if ((r_state == StShift) && w_slot_start) begin
                r_shreg   <= r_shreg << 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if ((r_state == StLoad) && w_slot_start) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_busy        = !w_idle;
    assign o_cfg_ready   = w_idle;
    assign o_done        = r_done;
    assign o_serial_load = r_load;
    assign o_serial_data = r_shreg[TOTAL-1];

endmodule
